// File: rtl/eem16_proj1_sweeper_if.sv
// Stimulus/result bundle between the truth-table sweeper and its surroundings.
// The slave side is the sweeper; the master side drives start and returns z.
interface eem16_proj1_sweeper_if;
  logic       start;
  logic       z;
  logic       x2;
  logic       x1;
  logic       x0;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] truth_table;
  logic [2:0] mismatch_idx;

  modport master (
    output start, z,
    input  x2, x1, x0, busy, done, pass, truth_table, mismatch_idx
  );

  modport slave (
    input  start, z,
    output x2, x1, x0, busy, done, pass, truth_table, mismatch_idx
  );
endinterface

// File: rtl/eem16_proj1_sweeper.sv
// Walks a 3-input combinational block through codes 000..111, samples z after
// a settle period, and checks the captured truth table against EXPECTED.
module eem16_proj1_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h96
) (
  input logic clk,
  input logic rst,
  eem16_proj1_sweeper_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    CHECK,
    DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] idx_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [7:0] table_q;
  logic [2:0] mismatch_q;
  logic [7:0] diff;
  logic [2:0] first_diff;
  logic       found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = SETTLE;
      SETTLE:     if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:     state_d = (idx_q == 3'd7) ? CHECK : SETTLE;
      CHECK:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Lowest differing code wins, so scan upward and latch the first hit.
  always_comb begin
    diff       = table_q ^ EXPECTED;
    first_diff = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (diff[i] && !found) begin
        first_diff = 3'(i);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      table_q    <= '0;
      mismatch_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            table_q    <= '0;
            mismatch_q <= '0;
          end
        end
        SETTLE: cnt_q <= cnt_q + 4'd1;
        SAMPLE: begin
          table_q[idx_q] <= bus.z;
          cnt_q          <= '0;
          if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
        end
        CHECK: begin
          pass_q     <= (diff == '0);
          mismatch_q <= first_diff;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The stimulus code is the registered index itself, so x holds 111 after the sweep.
  assign {bus.x2, bus.x1, bus.x0} = idx_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.pass                 = pass_q;
  assign bus.truth_table          = table_q;
  assign bus.mismatch_idx         = mismatch_q;

endmodule

// File: tb/tb_eem16_proj1_sweeper.sv
// Scoreboard bench for the sweeper: two instances (settle 4 and settle 1), each
// driving a modelled block whose truth table the bench picks per sweep.
module tb_eem16_proj1_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eem16_proj1_sweeper_if b0 ();
  eem16_proj1_sweeper_if b1 ();

  eem16_proj1_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'h96)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  eem16_proj1_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h96)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic       start_d [2];
  logic [7:0] tt_blk  [2];
  logic [2:0] xo      [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       pass_o  [2];
  logic [7:0] table_o [2];
  logic [2:0] mm_o    [2];

  assign b0.start = start_d[0];
  assign b1.start = start_d[1];
  assign xo[0] = {b0.x2, b0.x1, b0.x0};
  assign xo[1] = {b1.x2, b1.x1, b1.x0};
  assign b0.z = tt_blk[0][xo[0]];
  assign b1.z = tt_blk[1][xo[1]];
  assign busy_o[0] = b0.busy;         assign busy_o[1] = b1.busy;
  assign done_o[0] = b0.done;         assign done_o[1] = b1.done;
  assign pass_o[0] = b0.pass;         assign pass_o[1] = b1.pass;
  assign table_o[0] = b0.truth_table; assign table_o[1] = b1.truth_table;
  assign mm_o[0] = b0.mismatch_idx;   assign mm_o[1] = b1.mismatch_idx;

  typedef struct packed {
    logic [7:0] tt;
    logic       pass;
    logic [2:0] mm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last_exp [2];
  exp_t e;

  int tests = 0;
  int fails = 0;

  function automatic int sc(int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int lat(int u);
    return 8 * (sc(u) + 1) + 1;
  endfunction

  function automatic exp_t model(logic [7:0] tt);
    exp_t r;
    logic [7:0] d;
    r.tt   = tt;
    r.pass = (tt == 8'h96);
    r.mm   = '0;
    d      = tt ^ 8'h96;
    for (int i = 7; i >= 0; i--) if (d[i]) r.mm = 3'(i);
    return r;
  endfunction

  task automatic chk(input string name, input int u, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s unit%0d t=%0t: got %0h expected %0h", name, u, $time, act, exp);
    end
  endtask

  // Monitor: start/rst as seen at the active edge, outputs compared on the falling edge.
  logic rst_seen;
  logic start_seen [2];
  always @(posedge clk) begin
    rst_seen      <= rst;
    start_seen[0] <= start_d[0];
    start_seen[1] <= start_d[1];
  end

  bit active   [2];
  int k        [2];
  bit armed = 1'b0;
  logic done_prev [2];
  int code;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst_seen === 1'b1) begin
        armed     = 1'b1;
        active[u] = 1'b0;
        k[u]      = 0;
        if (u == 0) q0.delete(); else q1.delete();
        chk("rst_x", u, 8'(xo[u]), 8'h0);
        chk("rst_busy", u, 8'(busy_o[u]), 8'h0);
        chk("rst_done", u, 8'(done_o[u]), 8'h0);
        chk("rst_pass", u, 8'(pass_o[u]), 8'h0);
        chk("rst_table", u, table_o[u], 8'h0);
        chk("rst_mm", u, 8'(mm_o[u]), 8'h0);
      end else if (armed) begin
        if (start_seen[u] === 1'b1 && !(active[u] && k[u] < lat(u))) begin
          active[u] = 1'b1;
          k[u]      = 0;
          e         = model(tt_blk[u]);
          last_exp[u] = e;
          if (u == 0) q0.push_back(e); else q1.push_back(e);
        end else if (active[u] && k[u] < lat(u)) begin
          k[u]++;
        end
        code = active[u] ? k[u] / (sc(u) + 1) : 0;
        if (code > 7) code = 7;
        chk("x", u, 8'(xo[u]), 8'(code));
        chk("busy", u, 8'(busy_o[u]), 8'(active[u] && k[u] < lat(u)));
        chk("done", u, 8'(done_o[u]), 8'(active[u] && k[u] == lat(u)));
        if (active[u] && k[u] < lat(u)) begin
          chk("pass_busy", u, 8'(pass_o[u]), 8'h0);
          chk("mm_busy", u, 8'(mm_o[u]), 8'h0);
        end
        if (active[u] && k[u] == lat(u)) begin
          chk("hold_table", u, table_o[u], last_exp[u].tt);
          chk("hold_pass", u, 8'(pass_o[u]), 8'(last_exp[u].pass));
        end
        if (done_o[u] === 1'b1 && done_prev[u] !== 1'b1) begin
          if ((u == 0 ? q0.size() : q1.size()) == 0) begin
            chk("sb_empty", u, 8'h1, 8'h0);
          end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk("table", u, table_o[u], e.tt);
            chk("pass", u, 8'(pass_o[u]), 8'(e.pass));
            chk("mismatch_idx", u, 8'(mm_o[u]), 8'(e.mm));
          end
        end
      end
      done_prev[u] = done_o[u];
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int u);
    start_d[u] = 1'b1;
    @(negedge clk);
    start_d[u] = 1'b0;
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while (done_o[u] !== 1'b1 && n < lat(u) + 5) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_o[u] !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout unit%0d: done=%b after %0d cycles, required 1", u, done_o[u], n);
    end
  endtask

  task automatic run(input int u, input logic [7:0] tt);
    tt_blk[u] = tt;
    pulse_start(u);
    wait_done(u);
  endtask

  task automatic random_sweeps(input int u, input int count);
    for (int n = 0; n < count; n++) begin
      tt_blk[u] = ($urandom_range(0, 3) == 0) ? 8'h96 : 8'($urandom);
      cycles($urandom_range(0, 3));
      pulse_start(u);
      if ($urandom_range(0, 1) == 1) begin
        cycles($urandom_range(1, lat(u) - 4));
        pulse_start(u);
      end
      wait_done(u);
    end
  endtask

  initial begin
    start_d[0] = 1'b0;
    start_d[1] = 1'b0;
    tt_blk[0]  = 8'h96;
    tt_blk[1]  = 8'h96;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);

    run(0, 8'h96);
    run(0, 8'h00);
    run(0, 8'hFF);

    // extra starts seen at edges 3 and 20 of the sweep
    tt_blk[0] = 8'h96;
    pulse_start(0);
    cycles(2);
    pulse_start(0);
    cycles(16);
    pulse_start(0);
    wait_done(0);
    pulse_start(0);
    wait_done(0);

    // reset while idx=3, then a clean sweep
    tt_blk[0] = 8'h96;
    pulse_start(0);
    cycles(16);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    run(0, 8'h96);

    random_sweeps(0, 8);

    // two-clock reset at a random point of a sweep
    tt_blk[0] = 8'($urandom);
    pulse_start(0);
    cycles($urandom_range(1, 35));
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);

    run(1, 8'h96);
    run(1, 8'h00);
    random_sweeps(1, 8);
    run(0, 8'h96);

    cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
